// File: rtl/commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : commit_arbiter
// Brief    : Round-robin merge of per-unit commit streams into one registered
//            writeback stream, with a source lock for multi-beat instructions.
// Revision : 1.0 - initial release
// ============================================================================
module commit_arbiter #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 in_valid_i,
    output logic [NUM_INPUTS-1:0]                 in_ready_o,
    input  logic [NUM_INPUTS*NW_BITS-1:0]         in_wid_i,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0]     in_tmask_i,
    input  logic [NUM_INPUTS*32-1:0]              in_pc_i,
    input  logic [NUM_INPUTS*NR_BITS-1:0]         in_rd_i,
    input  logic [NUM_INPUTS-1:0]                 in_wb_i,
    input  logic [NUM_INPUTS*NUM_THREADS*32-1:0]  in_data_i,
    input  logic [NUM_INPUTS-1:0]                 in_eop_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [NW_BITS-1:0]                    out_wid_o,
    output logic [NUM_THREADS-1:0]                out_tmask_o,
    output logic [31:0]                           out_pc_o,
    output logic [NR_BITS-1:0]                    out_rd_o,
    output logic                                  out_wb_o,
    output logic [NUM_THREADS*32-1:0]             out_data_o,
    output logic                                  out_eop_o,
    output logic [$clog2(NUM_INPUTS)-1:0]         out_src_o,
    output logic [63:0]                           instret_o
);

    localparam int SRC_W = $clog2(NUM_INPUTS);
    localparam int DW    = NUM_THREADS * 32;

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [SRC_W-1:0]       lock_src_q, lock_src_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                   out_valid_q;
    logic [NW_BITS-1:0]     out_wid_q;
    logic [NUM_THREADS-1:0] out_tmask_q;
    logic [31:0]            out_pc_q;
    logic [NR_BITS-1:0]     out_rd_q;
    logic                   out_wb_q;
    logic [DW-1:0]          out_data_q;
    logic                   out_eop_q;
    logic [SRC_W-1:0]       out_src_q;
    logic [63:0]            instret_q;

    logic                   w_enable;
    logic                   w_grant_vld;
    logic [SRC_W-1:0]       w_grant;
    logic                   w_fire;

    assign w_enable = !out_valid_q || out_ready_i;
    assign w_fire   = !reset && w_enable && w_grant_vld;

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            lock_src_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next state: any handshake re-arms the lock from that beat's eop.
    // While locked the grant is always lock_src, so rr_ptr stays put.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (w_fire) begin
            lock_src_d = w_grant;
            state_d    = in_eop_i[w_grant] ? ST_OPEN : ST_LOCKED;
            rr_ptr_d   = (w_grant == SRC_W'(NUM_INPUTS - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    // Grant: locked source only, else first valid scanning up from rr_ptr.
    always_comb begin
        int idx;
        w_grant     = lock_src_q;
        w_grant_vld = 1'b0;
        idx         = 0;
        if (state_q == ST_LOCKED) begin
            w_grant_vld = in_valid_i[lock_src_q];
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
                if (in_valid_i[SRC_W'(idx)]) begin
                    w_grant     = SRC_W'(idx);
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    assign in_ready_o = w_fire ? (NUM_INPUTS'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_tmask_q <= '0;
            out_pc_q    <= '0;
            out_rd_q    <= '0;
            out_wb_q    <= 1'b0;
            out_data_q  <= '0;
            out_eop_q   <= 1'b0;
            out_src_q   <= '0;
        end else if (w_enable) begin
            out_valid_q <= w_grant_vld;
            if (w_grant_vld) begin
                out_wid_q   <= in_wid_i[int'(w_grant)*NW_BITS +: NW_BITS];
                out_tmask_q <= in_tmask_i[int'(w_grant)*NUM_THREADS +: NUM_THREADS];
                out_pc_q    <= in_pc_i[int'(w_grant)*32 +: 32];
                out_rd_q    <= in_rd_i[int'(w_grant)*NR_BITS +: NR_BITS];
                out_wb_q    <= in_wb_i[w_grant];
                out_data_q  <= in_data_i[int'(w_grant)*DW +: DW];
                out_eop_q   <= in_eop_i[w_grant];
                out_src_q   <= w_grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (out_valid_q && out_ready_i && out_eop_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_wid_o   = out_wid_q;
    assign out_tmask_o = out_tmask_q;
    assign out_pc_o    = out_pc_q;
    assign out_rd_o    = out_rd_q;
    assign out_wb_o    = out_wb_q;
    assign out_data_o  = out_data_q;
    assign out_eop_o   = out_eop_q;
    assign out_src_o   = out_src_q;
    assign instret_o   = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_arbiter
// Brief    : Directed, table-driven self-checking bench for commit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_arbiter;

    localparam int N  = 5;
    localparam int NT = 4;
    localparam int NW = 2;
    localparam int NR = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*NW-1:0]   in_wid;
    logic [N*NT-1:0]   in_tmask;
    logic [N*32-1:0]   in_pc;
    logic [N*NR-1:0]   in_rd;
    logic [N-1:0]      in_wb;
    logic [N*NT*32-1:0] in_data;
    logic [N-1:0]      in_eop;
    logic              out_valid;
    logic              out_ready;
    logic [NW-1:0]     out_wid;
    logic [NT-1:0]     out_tmask;
    logic [31:0]       out_pc;
    logic [NR-1:0]     out_rd;
    logic              out_wb;
    logic [NT*32-1:0]  out_data;
    logic              out_eop;
    logic [2:0]        out_src;
    logic [63:0]       instret;

    int errors = 0;
    int checks = 0;

    commit_arbiter #(.NUM_INPUTS(N), .NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_wid_i(in_wid), .in_tmask_i(in_tmask), .in_pc_i(in_pc), .in_rd_i(in_rd),
        .in_wb_i(in_wb), .in_data_i(in_data), .in_eop_i(in_eop),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_wid_o(out_wid), .out_tmask_o(out_tmask), .out_pc_o(out_pc), .out_rd_o(out_rd),
        .out_wb_o(out_wb), .out_data_o(out_data), .out_eop_o(out_eop),
        .out_src_o(out_src), .instret_o(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] eop;
        logic         rdy;
        logic [N-1:0] exp_ready;
        logic         exp_ov;
        logic [2:0]   exp_src;
        logic [63:0]  exp_instret;
    } vec_t;

    function automatic logic [31:0] pat_pc(input int s);
        return 32'h1000_0000 + 32'(s) * 32'h100;
    endfunction

    function automatic logic [NR-1:0] pat_rd(input int s);
        return NR'(s + 3);
    endfunction

    function automatic logic [NT*32-1:0] pat_data(input int s);
        logic [NT*32-1:0] d;
        for (int t = 0; t < NT; t++) d[t*32 +: 32] = 32'hD000_0000 + 32'(s * 16 + t);
        return d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int s);
        in_wid[s*NW +: NW]   = NW'(s + 1);
        in_tmask[s*NT +: NT] = NT'(s * 3 + 1);
        in_pc[s*32 +: 32]    = pat_pc(s);
        in_rd[s*NR +: NR]    = pat_rd(s);
        in_wb[s]             = 1'(s % 2);
        in_data[s*NT*32 +: NT*32] = pat_data(s);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; in_eop = '1; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [2:0] s);
        check({tag, " out_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, " out_src"}, 128'(out_src), 128'(s));
        check({tag, " out_pc"}, 128'(out_pc), 128'(pat_pc(int'(s))));
        check({tag, " out_rd"}, 128'(out_rd), 128'(pat_rd(int'(s))));
        check({tag, " out_data"}, 128'(out_data), 128'(pat_data(int'(s))));
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] v, input logic [4:0] e, input logic r,
                                input logic [4:0] er, input logic eo, input logic [2:0] es,
                                input logic [63:0] ei);
        vec_t x;
        x.valid = v; x.eop = e; x.rdy = r; x.exp_ready = er;
        x.exp_ov = eo; x.exp_src = es; x.exp_instret = ei;
        return x;
    endfunction

    initial begin
        // Round-robin: all valid, grant 0..4 twice, then idle
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 0));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00010, 1, 1, 1));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00100, 1, 2, 2));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b01000, 1, 3, 3));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b10000, 1, 4, 4));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00001, 1, 0, 5));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00010, 1, 1, 6));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b00100, 1, 2, 7));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b01000, 1, 3, 8));
        vecs.push_back(mk(5'b11111, 5'b11111, 1, 5'b10000, 1, 4, 9));
        vecs.push_back(mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 4, 10));
        // Lock on LSU for 3 beats with ALU/FPU waiting; then FPU, ALU
        vecs.push_back(mk(5'b00010, 5'b11101, 1, 5'b00010, 1, 1, 10));
        vecs.push_back(mk(5'b10011, 5'b11101, 1, 5'b00010, 1, 1, 10));
        vecs.push_back(mk(5'b10011, 5'b11111, 1, 5'b00010, 1, 1, 10));
        vecs.push_back(mk(5'b10001, 5'b11111, 1, 5'b10000, 1, 4, 11));
        vecs.push_back(mk(5'b00001, 5'b11111, 1, 5'b00001, 1, 0, 12));
        vecs.push_back(mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 0, 13));
        // Backpressure: 3 sources valid, out_ready low for 4 cycles
        vecs.push_back(mk(5'b00111, 5'b11111, 1, 5'b00010, 1, 1, 13));
        vecs.push_back(mk(5'b00101, 5'b11111, 0, 5'b00000, 1, 1, 13));
        vecs.push_back(mk(5'b00101, 5'b11111, 0, 5'b00000, 1, 1, 13));
        vecs.push_back(mk(5'b00101, 5'b11111, 0, 5'b00000, 1, 1, 13));
        vecs.push_back(mk(5'b00101, 5'b11111, 0, 5'b00000, 1, 1, 13));
        vecs.push_back(mk(5'b00101, 5'b11111, 1, 5'b00100, 1, 2, 14));
        vecs.push_back(mk(5'b00001, 5'b11111, 1, 5'b00001, 1, 0, 15));
        vecs.push_back(mk(5'b00000, 5'b11111, 1, 5'b00000, 0, 0, 16));

        for (int s = 0; s < N; s++) set_fields(s);

        // Reset state, with every source requesting
        reset = 1'b1; in_valid = '1; in_eop = '1; out_ready = 1'b1;
        #1;
        check("ready during reset", 128'(in_ready), 128'(0));
        step(); step();
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset out_src", 128'(out_src), 128'(0));
        check("reset out_pc", 128'(out_pc), 128'(0));
        check("reset instret", 128'(instret), 128'(0));
        in_valid = '0;
        reset = 1'b0;

        foreach (vecs[i]) begin
            in_valid = vecs[i].valid; in_eop = vecs[i].eop; out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ready));
            step();
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            check($sformatf("vec%0d instret", i), 128'(instret), 128'(vecs[i].exp_instret));
            if (vecs[i].exp_ov) check_beat($sformatf("vec%0d", i), vecs[i].exp_src);
        end

        // Single FPU beat with specific fields
        do_reset();
        in_wid[4*NW +: NW] = 2'd1; in_tmask[4*NT +: NT] = 4'b1011;
        in_pc[4*32 +: 32] = 32'h8000_0010; in_rd[4*NR +: NR] = 5'd7; in_wb[4] = 1'b1;
        in_valid = 5'b10000; in_eop = 5'b11111; out_ready = 1'b1;
        #1;
        check("fpu in_ready", 128'(in_ready), 128'(5'b10000));
        step();
        check("fpu out_valid", 128'(out_valid), 128'(1));
        check("fpu out_src", 128'(out_src), 128'(4));
        check("fpu out_wid", 128'(out_wid), 128'(1));
        check("fpu out_tmask", 128'(out_tmask), 128'(4'b1011));
        check("fpu out_pc", 128'(out_pc), 128'(32'h8000_0010));
        check("fpu out_rd", 128'(out_rd), 128'(7));
        check("fpu out_wb", 128'(out_wb), 128'(1));
        check("fpu out_eop", 128'(out_eop), 128'(1));
        in_valid = '0;
        step();
        check("fpu drained", 128'(out_valid), 128'(0));
        check("fpu instret", 128'(instret), 128'(1));
        set_fields(4);

        // Reset while locked on LSU
        do_reset();
        in_valid = 5'b00100; in_eop = 5'b11111;
        #1; check("rst-lock csr ready", 128'(in_ready), 128'(5'b00100));
        step(); check_beat("rst-lock csr", 3'd2);
        in_valid = 5'b00010; in_eop = 5'b11101;
        #1; check("rst-lock lsu ready", 128'(in_ready), 128'(5'b00010));
        step(); check_beat("rst-lock lsu", 3'd1);
        check("rst-lock instret pre", 128'(instret), 128'(1));
        in_valid = 5'b00011; reset = 1'b1;
        #1; check("rst-lock ready in reset", 128'(in_ready), 128'(0));
        step();
        check("rst-lock out_valid", 128'(out_valid), 128'(0));
        check("rst-lock instret", 128'(instret), 128'(0));
        reset = 1'b0; in_eop = 5'b11111;
        #1; check("rst-lock post ready", 128'(in_ready), 128'(5'b00001));
        step(); check_beat("rst-lock post", 3'd0);

        // Locked MUL goes idle while ALU waits
        do_reset();
        in_valid = 5'b01000; in_eop = 5'b10111;
        #1; check("idle mul ready", 128'(in_ready), 128'(5'b01000));
        step(); check_beat("idle mul beat0", 3'd3);
        in_valid = 5'b00001; in_eop = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            #1; check($sformatf("idle c%0d alu ready", c), 128'(in_ready), 128'(0));
            step(); check($sformatf("idle c%0d out_valid", c), 128'(out_valid), 128'(0));
        end
        in_valid = 5'b01001;
        #1; check("idle mul eop ready", 128'(in_ready), 128'(5'b01000));
        step(); check_beat("idle mul beat1", 3'd3);
        check("idle instret0", 128'(instret), 128'(0));
        in_valid = 5'b00001;
        #1; check("idle alu ready", 128'(in_ready), 128'(5'b00001));
        step(); check_beat("idle alu", 3'd0);
        check("idle instret1", 128'(instret), 128'(1));
        in_valid = '0;
        step();
        check("idle instret2", 128'(instret), 128'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
